diagonal_monitor: RTL

Sampling checker that sits at the consuming end of the diagonal-walker X/Y output pair. On each qualified sample it checks the walker invariant X >= Y, latches the first violating pair and its sample index, counts samples, and flags a stalled walker. It exposes a combinational invariant bit for formal properties and registered sticky status for the bench and for downstream logic.

---
 rtl/diagonal_monitor.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/diagonal_monitor.sv
// Sampling checker for the diagonal-walker X/Y pair: checks X >= Y on each
// qualified sample, latches the first violation, counts samples and detects stalls.
module diagonal_monitor #(
  parameter int W         = 4,
  parameter int CNT_W     = 8,
  parameter int STALL_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  output logic             prop,
  output logic             fail,
  output logic [W-1:0]     fail_x,
  output logic [W-1:0]     fail_y,
  output logic [CNT_W-1:0] fail_idx,
  output logic [CNT_W-1:0] samples,
  output logic             stall,
  output logic [1:0]       state
);

  localparam int REP_W = $clog2(STALL_MAX + 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(STALL_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAIL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               fail_q, fail_d;
  logic [W-1:0]       fail_x_q, fail_x_d;
  logic [W-1:0]       fail_y_q, fail_y_d;
  logic [CNT_W-1:0]   fail_idx_q, fail_idx_d;
  logic [CNT_W-1:0]   samples_q, samples_d;
  logic               stall_q, stall_d;
  logic [W-1:0]       prev_x_q, prev_x_d;
  logic [W-1:0]       prev_y_q, prev_y_d;
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;

  logic               viol;
  logic               same;
  logic [REP_W-1:0]   rep_inc;
  logic [CNT_W-1:0]   samples_inc;

  always_comb begin
    viol        = (x < y);
    same        = (x == prev_x_q) && (y == prev_y_q);
    rep_inc     = (rep_cnt_q == REP_MAX) ? REP_MAX : rep_cnt_q + 1'b1;
    samples_inc = (samples_q == CNT_MAX) ? samples_q : samples_q + 1'b1;

    state_d    = state_q;
    fail_d     = fail_q;
    fail_x_d   = fail_x_q;
    fail_y_d   = fail_y_q;
    fail_idx_d = fail_idx_q;
    samples_d  = samples_q;
    stall_d    = stall_q;
    prev_x_d   = prev_x_q;
    prev_y_d   = prev_y_q;
    rep_cnt_d  = rep_cnt_q;

    if (clr) begin
      // Clear wins over a coincident sample, which is dropped.
      state_d    = IDLE;
      fail_d     = 1'b0;
      fail_x_d   = '0;
      fail_y_d   = '0;
      fail_idx_d = '0;
      samples_d  = '0;
      stall_d    = 1'b0;
      prev_x_d   = '0;
      prev_y_d   = '0;
      rep_cnt_d  = '0;
    end else if (en) begin
      case (state_q)
        IDLE: begin
          prev_x_d  = x;
          prev_y_d  = y;
          samples_d = CNT_W'(1);
          rep_cnt_d = '0;
          if (viol) begin
            fail_d     = 1'b1;
            fail_x_d   = x;
            fail_y_d   = y;
            fail_idx_d = '0;
            state_d    = FAIL;
          end else begin
            state_d = TRACK;
          end
        end
        TRACK, FAIL: begin
          samples_d = samples_inc;
          prev_x_d  = x;
          prev_y_d  = y;
          if (same) begin
            rep_cnt_d = rep_inc;
            if (rep_inc == REP_MAX) stall_d = 1'b1;
          end else begin
            rep_cnt_d = '0;
          end
          // The first violation is frozen once FAIL is reached.
          if (state_q == TRACK && viol) begin
            fail_d     = 1'b1;
            fail_x_d   = x;
            fail_y_d   = y;
            fail_idx_d = samples_q;
            state_d    = FAIL;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fail_q     <= 1'b0;
      fail_x_q   <= '0;
      fail_y_q   <= '0;
      fail_idx_q <= '0;
      samples_q  <= '0;
      stall_q    <= 1'b0;
      prev_x_q   <= '0;
      prev_y_q   <= '0;
      rep_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      fail_q     <= fail_d;
      fail_x_q   <= fail_x_d;
      fail_y_q   <= fail_y_d;
      fail_idx_q <= fail_idx_d;
      samples_q  <= samples_d;
      stall_q    <= stall_d;
      prev_x_q   <= prev_x_d;
      prev_y_q   <= prev_y_d;
      rep_cnt_q  <= rep_cnt_d;
    end
  end

  assign prop     = !viol;
  assign fail     = fail_q;
  assign fail_x   = fail_x_q;
  assign fail_y   = fail_y_q;
  assign fail_idx = fail_idx_q;
  assign samples  = samples_q;
  assign stall    = stall_q;
  assign state    = state_q;

endmodule
